// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Sequences 64-bit instruction-pair fetches from the fetch stage onto a
//   single sram-like bus (addr_ok accepts the request, data_ok returns data).
//   One request is outstanding at a time. Redirects (flush) cancel an
//   in-flight fetch; the bus transfer still completes and its data is dropped.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   fetch_en, fetch_addr fetch request and PC from the fetch stage ([2:0] ignored)
//   flush                branch/prediction redirect
//   stall_o              freeze fetch PC while a fetch is in flight or held
//   inst_valid/ready     instruction pair handshake toward decode
//   inst_pc, inst_data   8-byte-aligned PC and {inst1, inst0}
//   bus_req, bus_addr    read request toward the bus bridge
//   bus_addr_ok          request accepted
//   bus_data_ok, rdata   response strobe and data
//   perf_fetch_cnt       delivered pairs (wrapping)
//   perf_stall_cnt       cycles with stall_o=1 (wrapping)
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_ADDR = 32'hbfbf_fff8,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             fetch_en,
   input  logic [31:0]      fetch_addr,
   input  logic             flush,
   output logic             stall_o,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst_pc,
   output logic [63:0]      inst_data,
   output logic             bus_req,
   output logic [31:0]      bus_addr,
   input  logic             bus_addr_ok,
   input  logic             bus_data_ok,
   input  logic [63:0]      bus_rdata,
   output logic [CNT_W-1:0] perf_fetch_cnt,
   output logic [CNT_W-1:0] perf_stall_cnt
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e state;
   logic   cancel;

   // Fetch PC low bits carry no information for an 8-byte-aligned fetch.
   logic unused_fetch_lsb;
   assign unused_fetch_lsb = ^fetch_addr[2:0];

   always_comb begin
      stall_o = 1'b0;
      case (state)
         StReq, StWait: stall_o = 1'b1;
         StHold:        stall_o = !inst_ready;
         default:       stall_o = 1'b0;
      endcase
      // A pending discard keeps the fetch stage frozen until it drains.
      if (cancel) stall_o = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state          <= StIdle;
         cancel         <= 1'b0;
         bus_req        <= 1'b0;
         bus_addr       <= RESET_ADDR;
         inst_pc        <= RESET_ADDR;
         inst_valid     <= 1'b0;
         inst_data      <= '0;
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (fetch_en && !flush) begin
                  bus_addr <= {fetch_addr[31:3], 3'b000};
                  inst_pc  <= {fetch_addr[31:3], 3'b000};
                  bus_req  <= 1'b1;
                  state    <= StReq;
               end
            end
            StReq: begin
               // Request stays up and stable until accepted, even on flush.
               if (flush) cancel <= 1'b1;
               if (bus_addr_ok) begin
                  bus_req <= 1'b0;
                  state   <= StWait;
               end
            end
            StWait: begin
               if (bus_data_ok) begin
                  cancel <= 1'b0;
                  if (cancel || flush) begin
                     state <= StIdle;
                  end else begin
                     inst_data  <= bus_rdata;
                     inst_valid <= 1'b1;
                     state      <= StHold;
                  end
               end else if (flush) begin
                  cancel <= 1'b1;
               end
            end
            StHold: begin
               if (flush || inst_ready) begin
                  inst_valid <= 1'b0;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase

         if (inst_valid && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(1);
         if (stall_o)                  perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
   end

endmodule
